uart_tx_buffer: RTL

- Downstream consumer of the core's output control register (result_bytes).
- Each byte the core commits is pushed into a small FIFO, then serialised onto a UART TX line as 8N1 (8 data bits, no parity, 1 stop bit), LSB first.
- Flow-control and overflow flags are packed into a 32-bit word that the core's status register samples, so software can poll before writing.

---
 rtl/uart_pkg.sv | 19 +
 rtl/sync_fifo.sv | 56 +++++
 rtl/uart_tx_buffer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART TX buffer.
//   tx_state_t : serialiser FSM states
//   STAT_*     : bit positions within the 32-bit status word
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a separate occupancy register.
//   clk, reset_n     : clock, async active-low reset (pointers/count only)
//   push, push_data  : write strobe and data
//   pop, pop_data    : read strobe; pop_data shows the head entry (show-ahead)
//   full, empty      : decoded from count
//   count            : current occupancy, 0..DEPTH
// A push while full is still accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int DATAW = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [DATAW-1:0]         push_data,
  input  logic                     pop,
  output logic [DATAW-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATAW-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             pop_ok, push_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem[rd_ptr];

  // Storage is not reset: contents are discarded by clearing the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte FIFO feeding an 8N1 UART transmitter (LSB first).
//   clk, reset_n : clock, async active-low reset (aborts any frame)
//   wr_en/wr_data: push one byte per high cycle
//   clr_overflow : clears the sticky overflow flag (a coincident drop wins)
//   txd          : registered serial line, idles high
//   full/empty/count : FIFO occupancy
//   busy         : a frame is in progress
//   status       : {.., count[15:8], .., ovf, busy, full, empty}
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int DATAW        = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          wr_en,
  input  logic [DATAW-1:0]              wr_data,
  input  logic                          clr_overflow,
  output logic                          txd,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          busy,
  output logic [31:0]                   status
);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATAW);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t        state;
  logic [BW-1:0]    baud_cnt;
  logic [IW-1:0]    bit_idx;
  logic [DATAW-1:0] shift, pop_data;
  logic             overflow, baud_end, pop, drop;

  assign baud_end = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  // Pops only on entry to START; gating on !empty also rules out pop-on-empty.
  assign pop  = !empty && ((state == IDLE) || (state == STOP && baud_end));
  assign drop = wr_en && full && !pop;
  assign busy = (state != IDLE);

  sync_fifo #(.DATAW(DATAW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      txd      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          txd      <= 1'b1;
          baud_cnt <= '0;
          if (pop) begin
            state <= START;
            shift <= pop_data;
            txd   <= 1'b0;
          end
        end
        START: begin
          if (baud_end) begin
            state    <= DATA;
            baud_cnt <= '0;
            bit_idx  <= '0;
            txd      <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == IW'(DATAW - 1)) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + IW'(1);
              shift   <= shift >> 1;
              txd     <= shift[1];   // next bit after the shift
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (pop) begin
              // Chain straight into the next frame without an idle bit.
              state <= START;
              shift <= pop_data;
              txd   <= 1'b0;
            end else begin
              state <= IDLE;
              txd   <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

  always_comb begin
    status                        = '0;
    status[STAT_EMPTY]            = empty;
    status[STAT_FULL]             = full;
    status[STAT_BUSY]             = busy;
    status[STAT_OVF]              = overflow;
    status[STAT_CNT_LSB +: CW]    = count;
  end

endmodule
